// File: rtl/integration_pkg.sv
// integration_pkg: shared AHB interconnect constants, address map and types.
// Revision 1.0
`default_nettype none

package integration_pkg;

  localparam int slave_number = 11;

  // Contiguous, disjoint slave windows covering 0..349.
  localparam logic [31:0] low_addr [slave_number] = '{
    32'd0,   32'd32,  32'd63,  32'd96,  32'd128, 32'd160,
    32'd192, 32'd224, 32'd256, 32'd288, 32'd320
  };

  localparam logic [31:0] high_addr [slave_number] = '{
    32'd31,  32'd62,  32'd95,  32'd127, 32'd159, 32'd191,
    32'd223, 32'd255, 32'd287, 32'd319, 32'd349
  };

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } transfer_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  localparam int DEFAULT_SLAVE_IDX = slave_number;

endpackage

`default_nettype wire

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped active transfers with the two-cycle ERROR response.
// Revision 1.0
`default_nettype none

module ahb_default_slave
  import integration_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic       i_unmapped,
  output logic       HREADYOUT,
  output logic [1:0] HRESP
);

  ds_state_t r_state;
  ds_state_t w_next;
  logic      w_start;

  assign w_start = HREADY && i_unmapped && ((HTRANS == NONSEQ) || (HTRANS == SEQ));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= DS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = DS_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = OKAY;
    case (r_state)
      DS_IDLE: begin
        w_next = w_start ? DS_ERR1 : DS_IDLE;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = ERROR;
        w_next    = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP  = ERROR;
        // A fresh unmapped transfer accepted here chains straight into ERR1.
        w_next = w_start ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        w_next = DS_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux: AHB address decoder, data-phase select register and response mux.
// Optional error counter enabled by AHB_DECODER_ERRCNT_EN. Revision 1.0
`default_nettype none

module ahb_decoder_mux
  import integration_pkg::*;
#(
  parameter int SLAVE_NUMBER = slave_number
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  output logic [SLAVE_NUMBER-1:0]    HSEL,
  input  logic [SLAVE_NUMBER*32-1:0] HRDATA_S,
  input  logic [SLAVE_NUMBER-1:0]    HREADYOUT_S,
  input  logic [SLAVE_NUMBER*2-1:0]  HRESP_S,
  output logic [31:0]                HRDATA,
  output logic                       HREADY,
  output logic [1:0]                 HRESP
`ifdef AHB_DECODER_ERRCNT_EN
  ,
  output logic [15:0]                ERR_COUNT
`endif
);

  localparam int DSEL_W = $clog2(DEFAULT_SLAVE_IDX + 1);

  logic [SLAVE_NUMBER-1:0] w_hsel;
  logic [DSEL_W-1:0]       w_dec_idx;
  logic                    w_unmapped;
  logic [DSEL_W-1:0]       r_dsel;
  logic                    w_ds_readyout;
  logic [1:0]              w_ds_resp;

  for (genvar i = 0; i < SLAVE_NUMBER; i++) begin : g_dec
    if (low_addr[i] == 32'd0) begin : g_lo_zero
      assign w_hsel[i] = (HADDR <= high_addr[i]);
    end else begin : g_lo_nonzero
      assign w_hsel[i] = (HADDR >= low_addr[i]) && (HADDR <= high_addr[i]);
    end
  end

  assign HSEL       = w_hsel;
  assign w_unmapped = ~|w_hsel;

  always_comb begin
    w_dec_idx = DSEL_W'(DEFAULT_SLAVE_IDX);
    for (int i = 0; i < SLAVE_NUMBER; i++) begin
      if (w_hsel[i]) begin
        w_dec_idx = DSEL_W'(i);
      end
    end
  end

  // The select only advances when the current data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel <= DSEL_W'(DEFAULT_SLAVE_IDX);
    end else if (HREADY) begin
      r_dsel <= w_dec_idx;
    end
  end

  ahb_default_slave u_default_slave (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .HTRANS     (HTRANS),
    .i_unmapped (w_unmapped),
    .HREADYOUT  (w_ds_readyout),
    .HRESP      (w_ds_resp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = w_ds_readyout;
    HRESP  = w_ds_resp;
    for (int i = 0; i < SLAVE_NUMBER; i++) begin
      if (r_dsel == DSEL_W'(i)) begin
        HRDATA = HRDATA_S[32*i +: 32];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[2*i +: 2];
      end
    end
  end

`ifdef AHB_DECODER_ERRCNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_count <= '0;
    end else if (HREADY && (HRESP == ERROR) && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign ERR_COUNT = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_decoder_mux.sv
// tb_ahb_decoder_mux: table-driven decode checks, directed corner sequences and
// randomized traffic against a behavioural model of ahb_decoder_mux.
`default_nettype none

module tb_ahb_decoder_mux;

  localparam int NS = 11;

  logic           hclk;
  logic           hreset;
  logic [31:0]    haddr;
  logic [1:0]     htrans;
  logic [NS-1:0]  hsel;
  logic [NS*32-1:0] hrdata_s;
  logic [NS-1:0]  hreadyout_s;
  logic [NS*2-1:0] hresp_s;
  logic [31:0]    hrdata;
  logic           hready;
  logic [1:0]     hresp;
  logic [15:0]    err_count;

  int checks;
  int errors;

  // Model state: data-phase owner (-1 = default slave), error phase, counter.
  int          m_dsel;
  int          m_ph;
  int          m_cnt;
  logic [31:0] e_rdata;
  logic        e_rdy;
  logic [1:0]  e_resp;

  int bnd [NS] = '{31, 62, 95, 127, 159, 191, 223, 255, 287, 319, 349};

  typedef struct {
    logic [31:0]   addr;
    logic [NS-1:0] sel;
  } dec_vec_t;

  dec_vec_t vecs [10];

  ahb_decoder_mux dut (
    .HCLK        (hclk),
    .HRESET      (hreset),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HSEL        (hsel),
    .HRDATA_S    (hrdata_s),
    .HREADYOUT_S (hreadyout_s),
    .HRESP_S     (hresp_s),
    .HRDATA      (hrdata),
    .HREADY      (hready),
    .HRESP       (hresp)
`ifdef AHB_DECODER_ERRCNT_EN
    ,
    .ERR_COUNT   (err_count)
`endif
  );

`ifndef AHB_DECODER_ERRCNT_EN
  assign err_count = 16'h0;
`endif

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    if (a > 32'd349) return -1;
    for (int i = 0; i < NS; i++) begin
      if (a <= 32'(bnd[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_dsel = -1;
    m_ph   = 0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    model_reset();
  endtask

  task automatic edge1();
    @(posedge hclk);
    #1;
  endtask

  task automatic model_expect();
    if (m_dsel >= 0) begin
      e_rdata = hrdata_s[m_dsel*32 +: 32];
      e_rdy   = hreadyout_s[m_dsel];
      e_resp  = hresp_s[m_dsel*2 +: 2];
    end else begin
      e_rdata = 32'h0;
      e_rdy   = (m_ph != 1);
      e_resp  = (m_ph == 0) ? 2'd0 : 2'd1;
    end
  endtask

  task automatic rnd_cycle();
    int d;
    if ($urandom_range(0, 3) != 0) haddr = 32'($urandom_range(0, 420));
    else haddr = $urandom;
    htrans = 2'($urandom_range(0, 3));
    hrdata_s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NS; i++) hreadyout_s[i] = ($urandom_range(0, 3) != 0);
    hresp_s = 22'($urandom);
    #2;
    model_expect();
    d = dec(haddr);
    chk("rnd_hsel", 32'(hsel), (d >= 0) ? (32'd1 << d) : 32'd0);
    chk("rnd_hrdata", hrdata, e_rdata);
    chk("rnd_hready", 32'(hready), 32'(e_rdy));
    chk("rnd_hresp", 32'(hresp), 32'(e_resp));
`ifdef AHB_DECODER_ERRCNT_EN
    chk("rnd_errcnt", 32'(err_count), 32'(m_cnt));
`endif
    @(posedge hclk);
    if (e_rdy && e_resp == 2'd1 && m_cnt < 65535) m_cnt++;
    if (m_ph == 1) m_ph = 2;
    else m_ph = (e_rdy && d < 0 && htrans[1]) ? 1 : 0;
    if (e_rdy) m_dsel = d;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hreset = 1'b1;
    haddr = 32'h0;
    htrans = 2'd0;
    hrdata_s = '1;
    hreadyout_s = '1;
    hresp_s = '0;
    model_reset();

    vecs[0] = '{32'd0,        11'b000_0000_0001};
    vecs[1] = '{32'd31,       11'b000_0000_0001};
    vecs[2] = '{32'd32,       11'b000_0000_0010};
    vecs[3] = '{32'd62,       11'b000_0000_0010};
    vecs[4] = '{32'd63,       11'b000_0000_0100};
    vecs[5] = '{32'h40,       11'b000_0000_0100};
    vecs[6] = '{32'd349,      11'b100_0000_0000};
    vecs[7] = '{32'd350,      11'b000_0000_0000};
    vecs[8] = '{32'h1000,     11'b000_0000_0000};
    vecs[9] = '{32'hFFFF_FFFF, 11'b000_0000_0000};

    // Decode is combinational and holds even while reset is asserted.
    for (int i = 0; i < 10; i++) begin
      haddr = vecs[i].addr;
      #1;
      chk($sformatf("hsel_addr_%0d", vecs[i].addr), 32'(hsel), 32'(vecs[i].sel));
    end

    do_reset();
    haddr = 32'h0;
    #1;
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // Wait-stated slave 2 followed by a pipelined unmapped NONSEQ.
    haddr = 32'h40; htrans = 2'd2; hreadyout_s = '1;
    edge1();
    hreadyout_s[2] = 1'b0;
    hrdata_s[2*32 +: 32] = 32'hA5A5_A5A5;
    haddr = 32'h1000;
    #1;
    chk("ws_hready_c1", 32'(hready), 32'd0);
    chk("ws_hsel_unmapped", 32'(hsel), 32'd0);
    edge1();
    chk("ws_hready_c2", 32'(hready), 32'd0);
    hreadyout_s[2] = 1'b1;
    #1;
    chk("ws_hready_done", 32'(hready), 32'd1);
    chk("ws_hrdata", hrdata, 32'hA5A5_A5A5);
    chk("ws_hresp", 32'(hresp), 32'd0);
    edge1();
    htrans = 2'd0;
    #1;
    chk("err_hready_c1", 32'(hready), 32'd0);
    chk("err_hresp_c1", 32'(hresp), 32'd1);
    chk("err_hrdata_c1", hrdata, 32'd0);
    edge1();
    chk("err_hready_c2", 32'(hready), 32'd1);
    chk("err_hresp_c2", 32'(hresp), 32'd1);
    edge1();
    chk("err_after_hready", 32'(hready), 32'd1);
    chk("err_after_hresp", 32'(hresp), 32'd0);

    // IDLE to an unmapped address is a zero-wait OKAY.
    haddr = 32'h1000; htrans = 2'd0;
    edge1();
    chk("idle_unm_hready", 32'(hready), 32'd1);
    chk("idle_unm_hresp", 32'(hresp), 32'd0);
    edge1();
    chk("idle_unm_hready2", 32'(hready), 32'd1);

    // Back-to-back unmapped NONSEQ then SEQ.
    do_reset();
    haddr = 32'd400; htrans = 2'd2;
    edge1();
    chk("chain_err1a_rdy", 32'(hready), 32'd0);
    chk("chain_err1a_resp", 32'(hresp), 32'd1);
    haddr = 32'd404; htrans = 2'd3;
    edge1();
    chk("chain_err2a_rdy", 32'(hready), 32'd1);
    chk("chain_err2a_resp", 32'(hresp), 32'd1);
    edge1();
    chk("chain_err1b_rdy", 32'(hready), 32'd0);
    chk("chain_err1b_resp", 32'(hresp), 32'd1);
    htrans = 2'd0;
    edge1();
    chk("chain_err2b_rdy", 32'(hready), 32'd1);
    chk("chain_err2b_resp", 32'(hresp), 32'd1);
    edge1();
    chk("chain_end_resp", 32'(hresp), 32'd0);
`ifdef AHB_DECODER_ERRCNT_EN
    chk("chain_errcnt", 32'(err_count), 32'd2);
`endif

    // Reset asserted in the middle of ERR1 must abort asynchronously.
    haddr = 32'd400; htrans = 2'd2;
    edge1();
    chk("rstmid_pre_rdy", 32'(hready), 32'd0);
    hreset = 1'b1;
    #1;
    chk("rstmid_hready", 32'(hready), 32'd1);
    chk("rstmid_hresp", 32'(hresp), 32'd0);
    chk("rstmid_hrdata", hrdata, 32'd0);
    htrans = 2'd0;
    edge1();
    hreset = 1'b0;
    model_reset();
    edge1();
    chk("rstmid_idle_rdy", 32'(hready), 32'd1);
    chk("rstmid_idle_resp", 32'(hresp), 32'd0);

    do_reset();
    for (int n = 0; n < 600; n++) rnd_cycle();

`ifdef AHB_DECODER_ERRCNT_EN
    do_reset();
    force dut.r_err_count = 16'hFFFE;
    #1;
    release dut.r_err_count;
    haddr = 32'd400; htrans = 2'd2;
    for (int n = 0; n < 6; n++) edge1();
    htrans = 2'd0;
    edge1();
    edge1();
    chk("sat_errcnt", 32'(err_count), 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_decoder_mux.md
# ahb_decoder_mux

Address decoder and slave-to-master response multiplexer for the AHB interconnect, sitting directly downstream of the arbiter. It takes the granted master's address-phase signals and drives one-hot `HSEL` to the 11 slaves. It registers the selection into the data phase and routes the selected slave's `HRDATA`/`HREADYOUT`/`HRESP` back as the global `HRDATA`/`HREADY`/`HRESP`. Unmapped addresses are served by an internal default slave that returns the two-cycle AHB ERROR response.

## Interface
- `SLAVE_NUMBER`, default `slave_number` (11): number of slave ports.
- `HCLK` in 1: bus clock; all state updates on rising edge.
- `HRESET` in 1: asynchronous, active-high reset.
- `HADDR` in 32: address from the arbiter's address mux (granted master).
- `HTRANS` in 2: `transfer_t` of the granted master.
- `HSEL` out `SLAVE_NUMBER`: one-hot slave select, combinational from `HADDR`.
- `HRDATA_S` in `SLAVE_NUMBER*32`: slave read data; slave i is bits [32i+31:32i].
- `HREADYOUT_S` in `SLAVE_NUMBER`: per-slave ready.
- `HRESP_S` in `SLAVE_NUMBER*2`: per-slave `resp_t`.
- `HRDATA` out 32: muxed read data to masters.
- `HREADY` out 1: global ready, fed back to all slaves, the arbiter and the masters.
- `HRESP` out 2: muxed response.
- `ERR_COUNT` out 16: present only with `AHB_DECODER_ERRCNT_EN`.

## Operation
- **Address decode**
  - Slave i is hit when `low_addr[i] <= HADDR <= high_addr[i]`, compared as unsigned 32-bit.
  - Ranges are contiguous and disjoint over 0..349.
  - `HADDR >= 350` is unmapped and selects the default slave; all `HSEL` bits are 0.
  - `HSEL` is independent of `HTRANS`. Slaves qualify the select with `HTRANS`.
- **Data-phase select register** `dsel` (slave index or DEFAULT)
  - Loaded from the current decode when `HREADY=1`; held when `HREADY=0`.
  - Reset value: DEFAULT.
- **Response mux**
  - `dsel` = slave i: outputs = `HRDATA_S[i]`, `HREADYOUT_S[i]`, `HRESP_S[i]`.
  - `dsel` = DEFAULT: outputs come from the default slave, with `HRDATA=0`.
- **Default slave FSM**, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: drives `HREADY=1`, `HRESP=OKAY`. If `HREADY=1`, the address is unmapped and `HTRANS` is NONSEQ or SEQ, the next state is DS_ERR1. Otherwise it stays in DS_IDLE.
  - DS_ERR1: drives `HREADY=0`, `HRESP=ERROR`. Always goes to DS_ERR2.
  - DS_ERR2: drives `HREADY=1`, `HRESP=ERROR`. Re-applies the DS_IDLE entry test: if the new unmapped active transfer qualifies, go to DS_ERR1, else go to DS_IDLE.
  - An IDLE or BUSY transfer to an unmapped address gets a zero-wait OKAY.
- **Reset behaviour**
  - Outputs during and after reset: `HREADY=1`, `HRESP=OKAY`, `HRDATA=0`, `ERR_COUNT=0`.
  - `HSEL` follows `HADDR` combinationally.
  - Asserting reset mid-error aborts to DS_IDLE immediately.

## Timing
- `HSEL` has zero-cycle latency from `HADDR` (combinational).
- The response mux is combinational from `dsel` and the slave inputs, adding no extra cycle.
- A transfer accepted at edge N is answered in the data phase starting at edge N.
- An unmapped active transfer accepted at edge N produces:
  - cycle N..N+1: `HREADY=0`, `HRESP=ERROR`;
  - cycle N+1..N+2: `HREADY=1`, `HRESP=ERROR`.
- A wait-stated slave (`HREADYOUT_S[i]=0`) freezes `dsel` and, through `HREADY`, the whole address pipeline.
- Back-to-back error transfers are supported: DS_ERR2 can chain directly into DS_ERR1.

## Configuration
- **`AHB_DECODER_ERRCNT_EN` defined:**
  - The `ERR_COUNT` port exists.
  - It increments by 1 on every cycle where `HREADY=1` and `HRESP=ERROR`, counting both slave and default-slave errors, once per completed error response.
  - It saturates at 0xFFFF and resets to 0.
- **Undefined:** the port and counter logic are absent. All other behaviour is identical.

## Structure
- `integration_pkg` holds the shared constants and types:
  - `low_addr`, `high_addr`, `slave_number`, `transfer_t` and `resp_t` (already shared);
  - new: `ds_state_t` enum for the FSM, and `DEFAULT_SLAVE_IDX = slave_number`, the DEFAULT encoding for `dsel`.
- Sub-module `ahb_default_slave` contains the FSM. Its inputs are `HCLK`, `HRESET`, `HREADY`, `HTRANS` and the unmapped-hit flag; its outputs are its own `HREADYOUT` and `HRESP`.

## Test plan
- **Reset:** assert `HRESET` mid-DS_ERR1 → `HREADY=1`, `HRESP=OKAY`, `HRDATA=0` asynchronously; FSM in DS_IDLE.
- **Range boundaries:** `HADDR` = 31, 32, 62, 63, 349, 350 → `HSEL` one-hot at bit 0, 1, 1, 2, 10, and none respectively.
- **Slave routing:** NONSEQ to 0x40 with `HREADYOUT_S[2]` low for 2 cycles and `HRDATA_S[2]=0xA5A5A5A5` → `HREADY` low 2 cycles, then `HRDATA=0xA5A5A5A5`, `HRESP=OKAY`; `dsel` stable throughout.
- **Unmapped error:** NONSEQ to 0x1000 → `HREADY` 0 then 1 with `HRESP=ERROR` both cycles. IDLE to 0x1000 → zero-wait OKAY.
- **Chained errors:** back-to-back NONSEQ, SEQ to 400, 404 → ERR1, ERR2, ERR1, ERR2 with no idle gap. With `AHB_DECODER_ERRCNT_EN`, `ERR_COUNT=2`.
- **Counter saturation (`AHB_DECODER_ERRCNT_EN`):** force the counter to 0xFFFE, issue 3 unmapped transfers → `ERR_COUNT` holds 0xFFFF.
